// File: rtl/bp_pkg.sv
// Shared encodings for the fetch-side branch pre-decoder: MIPS opcode/funct/rt
// fields and the instruction-kind classification handed to the predictor.
package bp_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    localparam logic [4:0] RA_REG     = 5'd31;

    typedef enum logic [2:0] {
        KIND_SEQ      = 3'd0,
        KIND_BRANCH   = 3'd1,
        KIND_JUMP     = 3'd2,
        KIND_CALL     = 3'd3,
        KIND_RET      = 3'd4,
        KIND_IND      = 3'd5,
        KIND_CALL_IND = 3'd6
    } kind_e;

endpackage

// File: rtl/extend.sv
// Sign-extends a 16-bit immediate to 32 bits.
module extend (
    input  logic [15:0] imm_i,
    output logic [31:0] ext_o
);

    assign ext_o = {{16{imm_i[15]}}, imm_i};

endmodule

// File: rtl/ras.sv
// Return-address stack: circular buffer whose top pointer names the most
// recent entry; a push into a full stack silently overwrites the oldest entry.
module ras #(
    parameter int DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [31:0]               data_i,
    output logic [31:0]               top_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_top;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_topInc;
    logic [PW-1:0] w_topDec;
    logic          w_full;
    logic          w_empty;

    assign w_topInc = r_top + PW'(1);
    assign w_topDec = r_top - PW'(1);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);

    assign top_o   = r_mem[r_top];
    assign count_o = r_count;
    assign empty_o = w_empty;
    assign full_o  = w_full;

    // Count saturates at DEPTH on overflow while the pointer keeps wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_top   <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push_i) begin
            r_top           <= w_topInc;
            r_mem[w_topInc] <= data_i;
            if (!w_full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (pop_i && !w_empty) begin
            r_top   <= w_topDec;
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/predecode_ras.sv
// Registered fetch-side pre-decoder: classifies each MIPS instruction, computes
// its static next PC and predicts JR $ra targets from a return-address stack.
module predecode_ras
    import bp_pkg::*;
#(
    parameter int RAS_DEPTH     = 8,
    parameter int LINK_OFFSET   = 4,
    parameter int EXT_BRANCH_EN = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [31:0]                   pc_i,
    input  logic [31:0]                   instr_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [31:0]                   pc_o,
    output logic [31:0]                   pc_next_o,
    output logic                          is_branch_o,
    output logic [2:0]                    kind_o,
    output logic                          ras_hit_o,
    output logic [$clog2(RAS_DEPTH):0]    ras_count_o
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_pcNext;
    kind_e       r_kind;
    logic        r_isBranch;
    logic        r_rasHit;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [5:0]  w_funct;
    logic [31:0] w_immExt;
    logic [31:0] w_p4;
    logic [31:0] w_jump;
    logic [31:0] w_branch;
    logic [31:0] w_link;
    logic        w_inReady;
    logic        w_accept;

    kind_e       w_kind;
    logic [31:0] w_next;
    logic        w_push;
    logic        w_pop;
    logic        w_hit;

    logic [31:0] w_rasTop;
    logic        w_rasEmpty;
    logic        w_rasFull;

    assign w_op    = instr_i[31:26];
    assign w_rs    = instr_i[25:21];
    assign w_rt    = instr_i[20:16];
    assign w_funct = instr_i[5:0];

    extend u_extend (
        .imm_i (instr_i[15:0]),
        .ext_o (w_immExt)
    );

    assign w_p4     = pc_i + 32'd4;
    assign w_jump   = {w_p4[31:28], instr_i[25:0], 2'b00};
    assign w_branch = w_p4 + {w_immExt[29:0], 2'b00};
    assign w_link   = pc_i + 32'(LINK_OFFSET);

    assign w_inReady = !r_valid || out_ready_i;
    assign w_accept  = in_valid_i && w_inReady && !flush_i;

    // Classification in priority order; a RET only pops when the stack has
    // something in it, otherwise it falls back to the sequential PC.
    always_comb begin
        w_kind = KIND_SEQ;
        w_next = w_p4;
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_hit  = 1'b0;
        if (w_op == OP_J) begin
            w_kind = KIND_JUMP;
            w_next = w_jump;
        end else if (w_op == OP_JAL) begin
            w_kind = KIND_CALL;
            w_next = w_jump;
            w_push = 1'b1;
        end else if (w_op == OP_SPECIAL && w_funct == FN_JR && w_rs == RA_REG) begin
            w_kind = KIND_RET;
            if (!w_rasEmpty) begin
                w_next = w_rasTop;
                w_pop  = 1'b1;
                w_hit  = 1'b1;
            end
        end else if (w_op == OP_SPECIAL && w_funct == FN_JR) begin
            w_kind = KIND_IND;
        end else if (w_op == OP_SPECIAL && w_funct == FN_JALR) begin
            w_kind = KIND_CALL_IND;
            w_push = 1'b1;
        end else if (w_op == OP_BEQ || w_op == OP_BNE) begin
            w_kind = KIND_BRANCH;
            w_next = w_branch;
        end else if (EXT_BRANCH_EN != 0 &&
                     (w_op == OP_BLEZ || w_op == OP_BGTZ ||
                      (w_op == OP_REGIMM && (w_rt == RT_BLTZ || w_rt == RT_BGEZ)))) begin
            w_kind = KIND_BRANCH;
            w_next = w_branch;
        end
    end

    ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_accept && w_push),
        .pop_i   (w_accept && w_pop),
        .data_i  (w_link),
        .top_o   (w_rasTop),
        .count_o (ras_count_o),
        .empty_o (w_rasEmpty),
        .full_o  (w_rasFull)
    );

    // Flush wins over accept; a stalled result holds every field unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_pcNext   <= '0;
            r_kind     <= KIND_SEQ;
            r_isBranch <= 1'b0;
            r_rasHit   <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_pc       <= pc_i;
            r_pcNext   <= w_next;
            r_kind     <= w_kind;
            r_isBranch <= (w_kind == KIND_BRANCH);
            r_rasHit   <= w_hit;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready_o  = w_inReady;
    assign out_valid_o = r_valid;
    assign pc_o        = r_pc;
    assign pc_next_o   = r_pcNext;
    assign kind_o      = r_kind;
    assign is_branch_o = r_isBranch;
    assign ras_hit_o   = r_rasHit;

endmodule

// File: doc/predecode_ras.md
Name: predecode_ras

Overview:
- Registered fetch-side pre-decoder for the branch predictor.
- Classifies each fetched MIPS instruction and computes its statically known next PC.
- Adds a parametrised return-address stack (RAS) that predicts JR $ra targets.
- Sits between the I-cache response and the predictor/BTB lookup, with valid/ready handshakes on both sides.

Parameters:
- RAS_DEPTH, 8, number of RAS entries; power of two, at least 2.
- LINK_OFFSET, 4, byte offset added to the call PC to form the pushed return address (4 or 8).
- EXT_BRANCH_EN, 1, when 1 also decodes BLEZ, BGTZ, BLTZ and BGEZ as conditional branches.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- flush_i  input  1  pipeline flush from the back end.
- in_valid_i  input  1  pc_i and instr_i are valid.
- in_ready_o  output  1  block accepts input this cycle.
- pc_i  input  32  fetch PC.
- instr_i  input  32  fetched instruction.
- out_valid_o  output  1  output register holds a result.
- out_ready_i  input  1  downstream consumes the result.
- pc_o  output  32  PC of the registered instruction.
- pc_next_o  output  32  predicted static next PC.
- is_branch_o  output  1  conditional branch; the dynamic predictor decides taken or not.
- kind_o  output  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 IND, 6 CALL_IND.
- ras_hit_o  output  1  RET target came from a non-empty RAS.
- ras_count_o  output  $clog2(RAS_DEPTH)+1  current RAS occupancy.

Behaviour:
- Reset (async): out_valid_o=0; pc_o, pc_next_o, kind_o, is_branch_o, ras_hit_o = 0; RAS pointer, count and all entries = 0.
- Handshake: in_ready_o = !out_valid_o | out_ready_i (combinational).
- Accept condition: in_valid_i & in_ready_o & !flush_i.
- On accept, the decode result is registered and out_valid_o=1 on the next cycle. Latency is 1 cycle and full throughput is supported.
- If out_valid_o & out_ready_i & no accept, out_valid_o clears next cycle.
- While out_valid_o & !out_ready_i, all outputs hold stable.
- Flush: out_valid_o clears next cycle and any same-cycle input is dropped with no RAS update. RAS contents are kept, not rolled back; flush has priority over accept.
- Next-PC arithmetic is modulo 2^32:
  - p4 = pc_i+4.
  - jump = {p4[31:28], instr[25:0], 2'b00}.
  - branch = p4 + (sign-extended imm16 << 2).
- Decode, in priority order:
  - op 000010 J: kind JUMP, next = jump.
  - op 000011 JAL: kind CALL, next = jump, push pc_i+LINK_OFFSET.
  - op 0, funct 001000 (JR), rs=31: kind RET. If the RAS is non-empty, pop; next = popped value, ras_hit=1. If empty: next = p4, ras_hit=0, RAS unchanged.
  - op 0, funct 001000 (JR), rs≠31: kind IND, next = p4.
  - op 0, funct 001001 (JALR): kind CALL_IND, next = p4, push pc_i+LINK_OFFSET.
  - op 000100 BEQ and 000101 BNE: kind BRANCH, is_branch=1, next = branch.
  - If EXT_BRANCH_EN: op 000110 BLEZ, op 000111 BGTZ, and op 000001 with rt 00000 (BLTZ) or 00001 (BGEZ) are also BRANCH.
  - Otherwise: kind SEQ, next = p4.
  - is_branch_o=1 only for kind BRANCH.
- RAS storage: circular buffer with top pointer and saturating count.
- RAS push:
  - top advances modulo RAS_DEPTH and the entry is written.
  - If count=RAS_DEPTH, the oldest entry is overwritten and count stays at RAS_DEPTH.
- RAS pop: the value is read combinationally from the current top; top decrements modulo RAS_DEPTH and count decrements.
- Push and pop never coincide, since there is one instruction per cycle.
- The RAS updates only on accept, so a stalled output never double-updates.

Decomposition:
- Package bp_pkg holds:
  - opcode/funct/rt constants;
  - kind_e enum (3-bit);
  - RA_REG = 5'd31.
- Sub-module ras: depth-parametrised circular stack with push_i, pop_i, data_i, top_o, count_o, empty_o, full_o and async reset.
- Decode logic and the output register stay in predecode_ras; sign extension is reused from the existing extend module.

Test Plan:
- Reset, then pc=0x00400000, instr=0x08100010 (J) -> next cycle out_valid=1, kind=JUMP, pc_next=0x00400040, is_branch=0.
- BEQ at 0x00400010 with imm 0xFFFF -> pc_next=0x00400010, is_branch=1, kind=BRANCH. BNE with imm 0x0004 -> pc_next=0x00400024.
- JAL at 0x00400100, then JR $ra (0x03E00008) -> RET with pc_next=0x00400104 (LINK_OFFSET=4), ras_hit=1, ras_count sequence 1 then 0.
  - JR $ra again -> pc_next = pc+4, ras_hit=0, count stays 0.
- RAS_DEPTH=8: 9 JALs at 0x100, 0x200, …, 0x900, then 9 JR $ra:
  - first 8 pops return 0x904 down to 0x204;
  - 9th misses;
  - ras_count saturates at 8.
- Hold out_ready_i=0 for 3 cycles with a JAL registered and the next instr presented -> outputs stable, in_ready_o=0, ras_count unchanged until release.
- flush_i together with a JAL input and a valid output -> out_valid=0 next cycle, ras_count unchanged. Assert rst_i mid-stream -> all outputs 0 immediately, ras_count=0.
